square_wave_gen: RTL and testbench

//   Programmable square-wave source: the generator counterpart of the frequency/duty meter.

---
 rtl/osc_pkg.sv | 19 +
 rtl/square_wave_gen_divider.sv | 54 +++++
 rtl/square_wave_gen.sv | 122 ++++++++++++
 tb/tb_square_wave_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the square-wave generator: default clock rate, sequencing
// states and duty full-scale.
package osc_pkg;

  localparam longint unsigned DEF_CLK_HZ = 100_000_000;
  localparam int unsigned     DUTY_FULL  = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_P = 2'd1,
    DIV_H = 2'd2,
    APPLY = 2'd3
  } state_t;

  function automatic logic [6:0] clamp_duty(input logic [6:0] duty);
    return (duty > 7'(DUTY_FULL)) ? 7'(DUTY_FULL) : duty;
  endfunction

endpackage

// File: rtl/square_wave_gen_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock; done pulses
// W+1 cycles after the start pulse.
module seq_divider #(
  parameter int W = 40
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] q
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  divisor;
  logic [CW-1:0] steps;
  logic [W:0]    trial;

  assign trial = {rem, quo[W-1]};
  assign q     = quo;

  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      steps   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        quo     <= a;
        divisor <= b;
        steps   <= CW'(W);
      end else if (steps != '0) begin
        if (trial >= {1'b0, divisor}) begin
          rem <= W'(trial - {1'b0, divisor});
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= trial[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        steps <= steps - CW'(1);
        done  <= (steps == CW'(1));
      end
    end
  end

endmodule

// File: rtl/square_wave_gen.sv
// Programmable square-wave source: converts a frequency/duty request into period and
// high-time clock counts and swaps them in glitch-free at the running wave's wrap.
//
// state | meaning
// IDLE  | waiting for load
// DIV_P | divider computing period = CLK_HZ / f
// DIV_H | divider computing high time = P*d / 100
// APPLY | waiting for the wrap (or immediate if stopped) to commit
module square_wave_gen
  import osc_pkg::*;
#(
  parameter longint unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int              FREQ_W = 28,
  parameter int              DIV_W  = 40
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              load,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic [6:0]        duty_in,
  output logic              busy,
  output logic              applied,
  output logic [31:0]       period_out,
  output logic              sign_out
);

  localparam logic [FREQ_W-1:0] F_MAX = FREQ_W'(CLK_HZ / 2);

  state_t            state, state_nxt;
  logic [FREQ_W-1:0] freq_q;
  logic [6:0]        duty_q;
  logic [DIV_W-1:0]  p_new;
  logic [31:0]       h_new;
  logic [DIV_W-1:0]  div_a, div_b, div_q;
  logic              div_done, kick;
  logic [31:0]       cnt, h_active;
  logic              accept, wrap, commit;

  assign accept = load && (state == IDLE);
  assign wrap   = (period_out != '0) && (cnt == period_out - 32'd1);
  assign commit = (state == APPLY) && ((period_out == '0) || wrap);

  always_ff @(posedge clk_100M) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = (freq_in == '0) ? APPLY : DIV_P;
      DIV_P:   if (div_done) state_nxt = DIV_H;
      DIV_H:   if (div_done) state_nxt = APPLY;
      APPLY:   if (commit)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    applied = commit;
    div_a   = DIV_W'(CLK_HZ);
    div_b   = DIV_W'(freq_q);
    if (state == DIV_H) begin
      div_a = p_new * DIV_W'(duty_q);
      div_b = DIV_W'(DUTY_FULL);
    end
  end

  // kick gives the divider its start pulse in the first cycle of each divide state
  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      kick   <= 1'b0;
      freq_q <= '0;
      duty_q <= '0;
      p_new  <= '0;
      h_new  <= '0;
    end else begin
      kick <= (state_nxt != state) && ((state_nxt == DIV_P) || (state_nxt == DIV_H));
      if (accept) begin
        freq_q <= (freq_in > F_MAX) ? F_MAX : freq_in;
        duty_q <= clamp_duty(duty_in);
        p_new  <= '0;
        h_new  <= '0;
      end
      if ((state == DIV_P) && div_done) p_new <= div_q;
      if ((state == DIV_H) && div_done) h_new <= div_q[31:0];
    end
  end

  seq_divider #(.W(DIV_W)) u_div (
    .clk_100M (clk_100M),
    .rst      (rst),
    .start    (kick),
    .a        (div_a),
    .b        (div_b),
    .done     (div_done),
    .q        (div_q)
  );

  // restarting cnt on commit makes the new setting open with a full high phase
  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      cnt        <= '0;
      period_out <= '0;
      h_active   <= '0;
      sign_out   <= 1'b0;
    end else begin
      sign_out <= (period_out != '0) && (cnt < h_active);
      if (commit) begin
        cnt        <= '0;
        period_out <= p_new[31:0];
        h_active   <= h_new;
      end else if (wrap || (period_out == '0)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: one 100 MHz-scaled instance and one CLK_HZ=1000 instance.
module tb_square_wave_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, load_a, busy_a, applied_a, sign_a;
  logic [27:0] freq_a;
  logic [6:0]  duty_a;
  logic [31:0] period_a;
  logic        rst_b, load_b, busy_b, applied_b, sign_b;
  logic [27:0] freq_b;
  logic [6:0]  duty_b;
  logic [31:0] period_b;

  int tests = 0;
  int fails = 0;

  square_wave_gen #(.CLK_HZ(100_000_000)) dut_a (
    .clk_100M(clk), .rst(rst_a), .load(load_a), .freq_in(freq_a), .duty_in(duty_a),
    .busy(busy_a), .applied(applied_a), .period_out(period_a), .sign_out(sign_a)
  );

  square_wave_gen #(.CLK_HZ(1000)) dut_b (
    .clk_100M(clk), .rst(rst_b), .load(load_b), .freq_in(freq_b), .duty_in(duty_b),
    .busy(busy_b), .applied(applied_b), .period_out(period_b), .sign_out(sign_b)
  );

  task automatic do_load(input bit sel, input int f, input int d);
    @(negedge clk);
    if (sel) begin load_b = 1'b1; freq_b = 28'(f); duty_b = 7'(d); end
    else     begin load_a = 1'b1; freq_a = 28'(f); duty_a = 7'(d); end
    @(posedge clk);
    #1;
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Returns at the negedge where applied is high (or after budget cycles).
  task automatic wait_applied(input bit sel, input int budget, output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel ? applied_b : applied_a) begin seen = 1'b1; break; end
      if (sel ? busy_b : busy_a) busy_cyc++;
    end
  endtask

  // Interval j after the applied cycle holds cnt=j-1, so sign_out = ((j-2) mod p) < h for j>=2.
  task automatic scan_wave(input bit sel, input int p, input int h, input int n,
                           output int errs, output int pulses);
    logic s, want;
    errs = 0;
    pulses = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      s = sel ? sign_b : sign_a;
      if (sel ? applied_b : applied_a) pulses++;
      if (j >= 2) begin
        want = (p == 0) ? 1'b0 : (((j - 2) % p) < h);
        if (s !== want) errs++;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if (busy_a !== 1'b0)     begin fails++; $display("FAIL reset_busy_a: got %0b want 0", busy_a); end
    tests++; if (applied_a !== 1'b0)  begin fails++; $display("FAIL reset_applied_a: got %0b want 0", applied_a); end
    tests++; if (period_a !== 32'd0)  begin fails++; $display("FAIL reset_period_a: got %0d want 0", period_a); end
    tests++; if (sign_a !== 1'b0)     begin fails++; $display("FAIL reset_sign_a: got %0b want 0", sign_a); end
    tests++; if (busy_b !== 1'b0)     begin fails++; $display("FAIL reset_busy_b: got %0b want 0", busy_b); end
    tests++; if (period_b !== 32'd0)  begin fails++; $display("FAIL reset_period_b: got %0d want 0", period_b); end
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic test_basic;
    int bc, errs, pulses;
    bit seen;
    do_load(0, 1_000_000, 50);
    wait_applied(0, 300, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL basic_applied_seen: got %0b want 1", seen); end
    tests++; if (bc !== 84)     begin fails++; $display("FAIL basic_busy_cycles: got %0d want 84", bc); end
    scan_wave(0, 100, 50, 250, errs, pulses);
    tests++; if (period_a !== 32'd100) begin fails++; $display("FAIL basic_period: got %0d want 100", period_a); end
    tests++; if (errs !== 0)   begin fails++; $display("FAIL basic_wave: got %0d bad samples want 0", errs); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL basic_applied_once: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_odd_ratio;
    int bc, errs, pulses;
    bit seen;
    do_load(1, 3, 33);
    wait_applied(1, 300, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL odd_applied_seen: got %0b want 1", seen); end
    tests++; if (bc !== 84)     begin fails++; $display("FAIL odd_busy_cycles: got %0d want 84", bc); end
    scan_wave(1, 333, 109, 700, errs, pulses);
    tests++; if (period_b !== 32'd333) begin fails++; $display("FAIL odd_period: got %0d want 333", period_b); end
    tests++; if (errs !== 0)   begin fails++; $display("FAIL odd_wave: got %0d bad samples want 0", errs); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL odd_applied_once: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_edges;
    int bc, errs, pulses;
    bit seen;
    do_load(1, 0, 50);
    wait_applied(1, 400, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL f0_applied_seen: got %0b want 1", seen); end
    scan_wave(1, 0, 0, 50, errs, pulses);
    tests++; if (period_b !== 32'd0) begin fails++; $display("FAIL f0_period: got %0d want 0", period_b); end
    tests++; if (errs !== 0) begin fails++; $display("FAIL f0_wave: got %0d bad samples want 0", errs); end

    do_load(1, 100, 0);
    wait_applied(1, 300, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL d0_applied_seen: got %0b want 1", seen); end
    scan_wave(1, 10, 0, 40, errs, pulses);
    tests++; if (period_b !== 32'd10) begin fails++; $display("FAIL d0_period: got %0d want 10", period_b); end
    tests++; if (errs !== 0) begin fails++; $display("FAIL d0_wave: got %0d bad samples want 0", errs); end

    do_load(1, 100, 120);
    wait_applied(1, 300, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL d120_applied_seen: got %0b want 1", seen); end
    scan_wave(1, 10, 10, 40, errs, pulses);
    tests++; if (errs !== 0) begin fails++; $display("FAIL d120_wave: got %0d bad samples want 0", errs); end
  endtask

  task automatic test_clamp;
    int bc, errs, pulses;
    bit seen;
    do_load(0, 60_000_000, 50);
    wait_applied(0, 400, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL clamp_applied_seen: got %0b want 1", seen); end
    scan_wave(0, 2, 1, 20, errs, pulses);
    tests++; if (period_a !== 32'd2) begin fails++; $display("FAIL clamp_period: got %0d want 2", period_a); end
    tests++; if (errs !== 0) begin fails++; $display("FAIL clamp_wave: got %0d bad samples want 0", errs); end
  endtask

  task automatic test_retarget;
    int bc, errs, pulses, idx, olderr;
    bit seen;
    logic want;
    do_load(0, 1_000_000, 50);
    wait_applied(0, 400, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL retgt_first_applied: got %0b want 1", seen); end
    repeat (31) @(negedge clk);
    load_a = 1'b1; freq_a = 28'd2_500_000; duty_a = 7'd50;
    idx = -1;
    olderr = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load_a = (i == 10);
      if (i == 10) freq_a = 28'd0;
      want = (((30 + i) % 100) < 50);
      if (sign_a !== want) olderr++;
      if (applied_a) begin idx = i; break; end
    end
    tests++; if (idx !== 168) begin fails++; $display("FAIL retgt_commit_at_wrap: got %0d want 168", idx); end
    tests++; if (olderr !== 0) begin fails++; $display("FAIL retgt_old_wave: got %0d bad samples want 0", olderr); end
    tests++; if (period_a !== 32'd100) begin fails++; $display("FAIL retgt_old_period: got %0d want 100", period_a); end
    scan_wave(0, 40, 20, 120, errs, pulses);
    tests++; if (period_a !== 32'd40) begin fails++; $display("FAIL retgt_new_period: got %0d want 40", period_a); end
    tests++; if (errs !== 0)   begin fails++; $display("FAIL retgt_new_wave: got %0d bad samples want 0", errs); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL retgt_ignored_load: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_mid_reset;
    int bc, errs, pulses;
    bit seen;
    do_load(0, 1_000_000, 50);
    repeat (60) @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %0b want 1", busy_a); end
    rst_a = 1'b0;
    @(negedge clk);
    tests++; if (busy_a !== 1'b0)    begin fails++; $display("FAIL mid_busy: got %0b want 0", busy_a); end
    tests++; if (applied_a !== 1'b0) begin fails++; $display("FAIL mid_applied: got %0b want 0", applied_a); end
    tests++; if (period_a !== 32'd0) begin fails++; $display("FAIL mid_period: got %0d want 0", period_a); end
    tests++; if (sign_a !== 1'b0)    begin fails++; $display("FAIL mid_sign: got %0b want 0", sign_a); end
    rst_a = 1'b1;
    do_load(0, 1_000_000, 50);
    wait_applied(0, 300, bc, seen);
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mid_applied_seen: got %0b want 1", seen); end
    tests++; if (bc !== 84)     begin fails++; $display("FAIL mid_busy_cycles: got %0d want 84", bc); end
    scan_wave(0, 100, 50, 220, errs, pulses);
    tests++; if (period_a !== 32'd100) begin fails++; $display("FAIL mid_period_after: got %0d want 100", period_a); end
    tests++; if (errs !== 0) begin fails++; $display("FAIL mid_wave: got %0d bad samples want 0", errs); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    load_a = 1'b0; load_b = 1'b0;
    freq_a = '0; freq_b = '0;
    duty_a = '0; duty_b = '0;
    repeat (3) @(posedge clk);
    test_reset;
    test_basic;
    test_odd_ratio;
    test_edges;
    test_clamp;
    test_retarget;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
